// File: rtl/cache_if.sv
// Bus bundle between the CPU load/store path, the cache controller and main memory.
// Signal suffixes are from the controller's point of view.
interface cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  cpu_ack_o;
    logic                  cpu_stall_o;
    logic                  flush_i;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ready_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic [CNT_WIDTH-1:0]  hit_cnt_o;
    logic [CNT_WIDTH-1:0]  miss_cnt_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, flush_i,
        input  mem_ready_i, mem_rdata_i,
        output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output hit_cnt_o, miss_cnt_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, flush_i,
        output mem_ready_i, mem_rdata_i,
        input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-per-line data cache controller.
// Write-through, no-write-allocate; read misses refill over the memory handshake.
//
// state   | meaning
// IDLE    | waiting for a CPU request or a flush
// LOOKUP  | tag compare; load hits complete here
// REFILL  | memory read for a load miss
// WRITE   | memory write-through for a store
// RESPOND | one-cycle ack after a memory transaction
module cache_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SET_WIDTH    = 3,
    parameter int TAG_WIDTH    = 27,
    parameter int CACHE_LENGTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input logic   clk,
    input logic   rst_n,
    cache_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESPOND} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    we_q;
    logic                    ack_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [CACHE_LENGTH-1:0] valid_q;
    logic [CNT_WIDTH-1:0]    hit_cnt_q,  hit_cnt_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

    logic [TAG_WIDTH-1:0]    tag_arr  [CACHE_LENGTH];
    logic [DATA_WIDTH-1:0]   data_arr [CACHE_LENGTH];

    logic [SET_WIDTH-1:0]    set;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    lookup;
    logic                    hit;

    assign set    = addr_q[SET_WIDTH+1:2];
    assign tag    = addr_q[ADDR_WIDTH-1:SET_WIDTH+2];
    assign lookup = (state_q == LOOKUP);
    assign hit    = valid_q[set] && (tag_arr[set] == tag);

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup && hit && (hit_cnt_q != '1))
            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        if (lookup && !hit && (miss_cnt_q != '1))
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.flush_i) begin
                        valid_q <= '0;
                    end else if (bus.cpu_req_i) begin
                        addr_q  <= bus.cpu_addr_i;
                        wdata_q <= bus.cpu_wdata_i;
                        we_q    <= bus.cpu_we_i;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= WRITE;
                    end else if (hit) begin
                        state_q <= IDLE;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ready_i) begin
                        rdata_q      <= bus.mem_rdata_i;
                        valid_q[set] <= 1'b1;
                        mem_req_q    <= 1'b0;
                        ack_q        <= 1'b1;
                        state_q      <= RESPOND;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= RESPOND;
                    end
                end
                RESPOND: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; state_q is forced to IDLE by reset so no write can slip through.
    always_ff @(posedge clk) begin
        if (lookup && we_q && hit) begin
            data_arr[set] <= wdata_q;
        end else if ((state_q == REFILL) && bus.mem_ready_i) begin
            data_arr[set] <= bus.mem_rdata_i;
            tag_arr[set]  <= tag;
        end
    end

    assign bus.cpu_ack_o   = ack_q | (lookup && !we_q && hit);
    assign bus.cpu_rdata_o = lookup ? data_arr[set] : rdata_q;
    assign bus.cpu_stall_o = bus.cpu_req_i & ~bus.cpu_ack_o;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = addr_q & ~ADDR_WIDTH'(3);
    assign bus.mem_wdata_o = wdata_q;
    assign bus.hit_cnt_o   = hit_cnt_q;
    assign bus.miss_cnt_o  = miss_cnt_q;
endmodule
